// File: rtl/prog_seq.sv
// Program sequencer: a small opcode memory stepped by decoder advance pulses.
// One-shot or looping runs, with abort, a completion pulse and a saturating pass counter.
module prog_seq #(
  parameter int DEPTH = 16,
  parameter int OPW   = 3,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_load_en,
  input  logic [AW-1:0]  i_load_addr,
  input  logic [OPW-1:0] i_load_instr,
  input  logic [AW-1:0]  i_end_addr,
  input  logic           i_loop,
  input  logic           i_run,
  input  logic           i_abort,
  input  logic           i_pcincr,
  output logic [OPW-1:0] o_instr,
  output logic [AW-1:0]  o_pc,
  output logic           o_busy,
  output logic           o_done,
  output logic [7:0]     o_iter,
  output logic [1:0]     o_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t         state;
  state_t         state_nxt;
  logic [OPW-1:0] mem [DEPTH];
  logic [AW-1:0]  pc;
  logic [AW-1:0]  end_addr_q;
  logic           loop_q;
  logic [7:0]     iter;

  logic          start;
  logic          advance;
  logic          at_end;
  logic [AW-1:0] pc_inc;
  logic [7:0]    iter_sat;

  // A load in the same cycle as a run request takes precedence; the run is dropped.
  assign start    = (state == S_IDLE) && i_run && !i_load_en;
  assign advance  = (state == S_RUN) && i_pcincr && !i_abort;
  assign at_end   = (pc == end_addr_q);
  assign pc_inc   = (pc == LAST_ADDR) ? '0 : pc + AW'(1);
  assign iter_sat = (iter == 8'hFF) ? iter : iter + 8'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (i_abort)                        state_nxt = S_IDLE;
        else if (advance && at_end && !loop_q) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc         <= '0;
      iter       <= '0;
      end_addr_q <= '0;
      loop_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc         <= '0;
            iter       <= '0;
            end_addr_q <= i_end_addr;
            loop_q     <= i_loop;
          end
        end
        S_RUN: begin
          if (i_abort) begin
            pc <= '0;
          end else if (i_pcincr) begin
            if (at_end) begin
              iter <= iter_sat;
              if (loop_q) pc <= '0;
            end else begin
              pc <= pc_inc;
            end
          end
        end
        S_DONE:  pc <= '0;
        default: pc <= '0;
      endcase
    end
  end

  // Program memory survives reset; writes are accepted only while idle.
  always_ff @(posedge i_clk) begin
    if (!i_rst && state == S_IDLE && i_load_en)
      mem[i_load_addr] <= i_load_instr;
  end

  always_comb begin
    o_busy  = 1'b0;
    o_done  = 1'b0;
    o_instr = '0;
    case (state)
      S_RUN: begin
        o_busy  = 1'b1;
        o_instr = mem[pc];
      end
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_pc    = pc;
  assign o_iter  = iter;
  assign o_state = state;

endmodule

// File: tb/tb_prog_seq.sv
// Bench for prog_seq: directed vector table, hand-written corner sequences and
// a randomized phase, all compared every cycle against a behavioural model.
module tb_prog_seq;

  localparam int DEPTH = 16;
  localparam int OPW   = 3;
  localparam int AW    = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           load_en = 1'b0;
  logic [AW-1:0]  load_addr = '0;
  logic [OPW-1:0] load_instr = '0;
  logic [AW-1:0]  end_addr = '0;
  logic           loop = 1'b0;
  logic           run = 1'b0;
  logic           abort = 1'b0;
  logic           pcincr = 1'b0;
  logic [OPW-1:0] instr;
  logic [AW-1:0]  pc;
  logic           busy;
  logic           done;
  logic [7:0]     iter;
  logic [1:0]     state_dbg;

  int tests = 0;
  int fails = 0;

  // Behavioural model: plain integers and flags for the run/done phases.
  int m_mem [DEPTH];
  bit m_busy = 0;
  bit m_done = 0;
  int m_pc = 0;
  int m_iter = 0;
  int m_end = 0;
  bit m_loop = 0;

  typedef struct {
    int gap;
    bit run;
    bit pcincr;
    bit abort;
    int e_instr;
    int e_pc;
    bit e_busy;
    bit e_done;
    int e_iter;
  } vec_t;

  vec_t vecs [6];
  int   exp37 [7] = '{1, 2, 0, 1, 2, 0, 1};

  prog_seq #(.DEPTH(DEPTH), .OPW(OPW)) dut (
    .i_clk(clk), .i_rst(rst), .i_load_en(load_en), .i_load_addr(load_addr),
    .i_load_instr(load_instr), .i_end_addr(end_addr), .i_loop(loop),
    .i_run(run), .i_abort(abort), .i_pcincr(pcincr), .o_instr(instr),
    .o_pc(pc), .o_busy(busy), .o_done(done), .o_iter(iter), .o_state(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_busy = 0; m_done = 0; m_pc = 0; m_iter = 0;
    end else if (m_done) begin
      m_done = 0; m_pc = 0;
    end else if (!m_busy) begin
      if (load_en) m_mem[load_addr] = load_instr;
      else if (run) begin
        m_busy = 1; m_pc = 0; m_iter = 0; m_end = end_addr; m_loop = loop;
      end
    end else if (abort) begin
      m_busy = 0; m_pc = 0;
    end else if (pcincr) begin
      if (m_pc == m_end) begin
        m_iter = (m_iter < 255) ? m_iter + 1 : 255;
        if (m_loop) m_pc = 0;
        else begin
          m_busy = 0; m_done = 1;
        end
      end else begin
        m_pc = (m_pc + 1) % DEPTH;
      end
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, " instr"}, int'(instr), m_busy ? m_mem[m_pc] : 0);
    check({tag, " pc"}, int'(pc), m_pc);
    check({tag, " busy"}, int'(busy), int'(m_busy));
    check({tag, " done"}, int'(done), int'(m_done));
    check({tag, " iter"}, int'(iter), m_iter);
  endtask

  task automatic quiet();
    rst = 0; load_en = 0; run = 0; abort = 0; pcincr = 0;
  endtask

  task automatic load(input int addr, input int op);
    load_en = 1; load_addr = AW'(addr); load_instr = OPW'(op);
    tick("load");
    load_en = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;

    // Reset state
    rst = 1;
    repeat (3) tick("reset");
    rst = 0;
    check("reset pc", int'(pc), 0);
    check("reset busy", int'(busy), 0);
    check("reset instr", int'(instr), 0);

    for (int i = 0; i < DEPTH; i++) load(i, (i * 3) % 8);
    load(0, 7); load(1, 4); load(2, 2);

    // One-shot run, advance every 8 cycles
    vecs[0] = '{gap: 0, run: 1, pcincr: 0, abort: 0, e_instr: 7, e_pc: 0, e_busy: 1, e_done: 0, e_iter: 0};
    vecs[1] = '{gap: 7, run: 0, pcincr: 1, abort: 0, e_instr: 4, e_pc: 1, e_busy: 1, e_done: 0, e_iter: 0};
    vecs[2] = '{gap: 7, run: 0, pcincr: 1, abort: 0, e_instr: 2, e_pc: 2, e_busy: 1, e_done: 0, e_iter: 0};
    vecs[3] = '{gap: 7, run: 0, pcincr: 1, abort: 0, e_instr: 0, e_pc: 2, e_busy: 0, e_done: 1, e_iter: 1};
    vecs[4] = '{gap: 0, run: 0, pcincr: 0, abort: 0, e_instr: 0, e_pc: 0, e_busy: 0, e_done: 0, e_iter: 1};
    vecs[5] = '{gap: 0, run: 0, pcincr: 1, abort: 1, e_instr: 0, e_pc: 0, e_busy: 0, e_done: 0, e_iter: 1};
    end_addr = 2; loop = 0;
    for (int i = 0; i < 6; i++) begin
      repeat (vecs[i].gap) tick("gap");
      run = vecs[i].run; pcincr = vecs[i].pcincr; abort = vecs[i].abort;
      tick("vec");
      quiet();
      check($sformatf("vec%0d instr", i), int'(instr), vecs[i].e_instr);
      check($sformatf("vec%0d pc", i), int'(pc), vecs[i].e_pc);
      check($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].e_busy));
      check($sformatf("vec%0d done", i), int'(done), int'(vecs[i].e_done));
      check($sformatf("vec%0d iter", i), int'(iter), vecs[i].e_iter);
    end

    // Looping run, 7 back-to-back advances
    loop = 1; run = 1; tick("loop start"); run = 0;
    check("loop pc0", int'(pc), 0);
    for (int k = 0; k < 7; k++) begin
      pcincr = 1; tick("loop"); pcincr = 0;
      check($sformatf("loop pc%0d", k + 1), int'(pc), exp37[k]);
      check("loop done", int'(done), 0);
    end
    check("loop iter", int'(iter), 2);
    abort = 1; tick("loop abort"); abort = 0;

    // Abort together with advance at pc=1
    loop = 0; run = 1; tick("ab start"); run = 0;
    pcincr = 1; tick("ab step");
    abort = 1; tick("ab hit"); quiet();
    check("abort busy", int'(busy), 0);
    check("abort pc", int'(pc), 0);
    check("abort instr", int'(instr), 0);
    check("abort done", int'(done), 0);

    // Write during RUN is dropped
    run = 1; tick("wr start"); run = 0;
    load_en = 1; load_addr = 1; load_instr = 3; tick("wr run"); load_en = 0;
    abort = 1; tick("wr abort"); abort = 0;
    run = 1; tick("wr rerun"); run = 0;
    pcincr = 1; tick("wr step"); pcincr = 0;
    check("dropped write", int'(instr), 4);
    abort = 1; tick("wr end"); abort = 0;

    // Reset mid-RUN, then rerun without reload
    run = 1; tick("rs start"); run = 0;
    pcincr = 1; tick("rs s1"); tick("rs s2"); pcincr = 0;
    check("rs pc2", int'(pc), 2);
    rst = 1; pcincr = 1; load_en = 1; load_addr = 0; load_instr = 1;
    tick("rs hit"); quiet();
    check("rs pc", int'(pc), 0);
    check("rs busy", int'(busy), 0);
    check("rs iter", int'(iter), 0);
    run = 1; tick("rs rerun"); run = 0;
    check("rs op0", int'(instr), 7);
    pcincr = 1; tick("rs a"); check("rs op1", int'(instr), 4);
    tick("rs b"); check("rs op2", int'(instr), 2);
    tick("rs c"); pcincr = 0;
    check("rs done", int'(done), 1);
    tick("rs idle");

    // Run request alongside a load: load wins
    run = 1; load_en = 1; load_addr = 5; load_instr = 6; tick("ld+run"); quiet();
    check("ld+run busy", int'(busy), 0);
    end_addr = 5; run = 1; tick("ld start"); run = 0;
    pcincr = 1; repeat (5) tick("ld step"); pcincr = 0;
    check("ld op5", int'(instr), 6);
    abort = 1; tick("ld end"); abort = 0;

    // Saturating pass counter
    end_addr = 0; loop = 1; run = 1; tick("sat start"); run = 0;
    pcincr = 1; repeat (300) tick("sat"); pcincr = 0;
    check("sat iter", int'(iter), 255);
    check("sat pc", int'(pc), 0);
    abort = 1; tick("sat abort"); abort = 0;
    check("sat held", int'(iter), 255);

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 99) == 0);
      load_en    = ($urandom_range(0, 7) == 0);
      load_addr  = AW'($urandom_range(0, DEPTH - 1));
      load_instr = OPW'($urandom_range(0, 7));
      end_addr   = AW'($urandom_range(0, 5));
      loop       = 1'($urandom_range(0, 1));
      run        = ($urandom_range(0, 3) == 0);
      abort      = ($urandom_range(0, 29) == 0);
      pcincr     = 1'($urandom_range(0, 1));
      tick("rand");
    end
    quiet();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prog_seq.md
PROG_SEQ -- requirements
Module: prog_seq

Interface
REQ-001 Parameter DEPTH, default 16, number of program memory entries; address width AW = clog2(DEPTH).
REQ-002 Parameter OPW, default 3, opcode width matching the decoder instruction input.
REQ-003 Single clock, reset synchronous and active-high; all state changes on posedge i_clk.
REQ-004 i_clk  input  1  system clock.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_load_en  input  1  write strobe for program memory.
REQ-007 i_load_addr  input  AW  program memory write address.
REQ-008 i_load_instr  input  OPW  opcode to write.
REQ-009 i_end_addr  input  AW  address of last program instruction; sampled on run start.
REQ-010 i_loop  input  1  1 = wrap to address 0 after last instruction; sampled on run start.
REQ-011 i_run  input  1  run request, level-sampled in IDLE.
REQ-012 i_abort  input  1  stop execution immediately.
REQ-013 i_pcincr  input  1  advance pulse from the decoder.
REQ-014 o_instr  output  OPW  opcode presented to the decoder.
REQ-015 o_pc  output  AW  current program counter.
REQ-016 o_busy  output  1  high in RUN.
REQ-017 o_done  output  1  one-cycle pulse on normal program completion.
REQ-018 o_iter  output  8  completed loop passes, saturating.

Function
REQ-019 States: IDLE, RUN, DONE; encoding free.
REQ-020 Memory writes occur only in IDLE when i_load_en=1: mem[i_load_addr] <= i_load_instr; writes in RUN or DONE are dropped.
REQ-021 IDLE, i_run=1, i_load_en=0 -> RUN next cycle; pc <= 0, iter <= 0, latch end_addr and loop.
REQ-022 IDLE with i_run=1 and i_load_en=1: write performed, run ignored that cycle.
REQ-023 o_instr = mem[pc] combinationally in RUN; o_instr = 0 (NOP awaiting start) in IDLE and DONE.
REQ-024 RUN, i_pcincr=1, pc != end_addr -> pc <= pc+1 next cycle.
REQ-025 RUN, i_pcincr=1, pc == end_addr, loop=1 -> pc <= 0, iter <= iter+1 saturating at 255, stay RUN.
REQ-026 RUN, i_pcincr=1, pc == end_addr, loop=0 -> DONE, iter <= iter+1 (saturating), pc held.
REQ-027 DONE lasts exactly one cycle with o_done=1, then IDLE with pc <= 0.
REQ-028 i_abort=1 in RUN -> IDLE next cycle, pc <= 0, o_done stays 0, iter held; abort wins over simultaneous i_pcincr.
REQ-029 i_pcincr and i_abort ignored in IDLE and DONE.
REQ-030 end_addr >= DEPTH cannot occur for power-of-two DEPTH; for non-power-of-two DEPTH, pc wraps to 0 after DEPTH-1 regardless of end_addr.
REQ-031 Latency: i_pcincr to new o_pc/o_instr = 1 cycle; i_run to o_busy = 1 cycle.
REQ-032 o_busy = 1 only in RUN; o_pc always reflects the pc register.

Reset
REQ-033 i_rst=1 at any clock edge forces IDLE, pc=0, iter=0, o_done=0, o_busy=0, o_instr=0, including mid-RUN.
REQ-034 Reset has priority over i_run, i_abort, i_pcincr and i_load_en; no memory write occurs in a reset cycle.
REQ-035 Program memory contents are not cleared by reset.

Verification
REQ-036 Load mem[0..2] = 111, 100, 010; end=2, loop=0; pulse run; pcincr every 8 cycles -> o_instr sequence 111, 100, 010; o_done one cycle after 3rd pcincr; o_iter=1; o_busy low afterwards.
REQ-037 Same program, loop=1, 7 pcincr pulses -> o_pc 0,1,2,0,1,2,0,1; o_iter=2; o_done never asserted.
REQ-038 RUN at pc=1, assert i_abort and i_pcincr together -> next cycle IDLE, o_pc=0, o_instr=000, o_done=0.
REQ-039 Write mem[1]=011 during RUN -> ignored; after return to IDLE, rerun reads the original opcode at address 1.
REQ-040 i_rst asserted mid-RUN at pc=2 -> next cycle o_pc=0, o_busy=0, o_iter=0; rerun without reload reproduces the program.
REQ-041 loop=1, end=0, 300 pcincr pulses -> o_iter saturates at 255, o_pc stays 0.
